// File: rtl/archie_mem_pkg.sv
// Shared types for the memory arbiter: arbiter state encoding and Wishbone
// cycle-type identifiers.
package archie_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_LOAD = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [3:0] SEL_HI_HALF = 4'b1100;
  localparam logic [3:0] SEL_LO_HALF = 4'b0011;

  // A core grant is released by an acked beat that is not part of a burst.
  function automatic logic cti_ends_cycle(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and RAM-side Wishbone signals of the memory arbiter, grouped so the
// arbiter (master modport) and its surroundings (slave modport) share one bundle.
interface mem_arbiter_if;
  // Handshake on both sides: a beat is requested while stb and cyc are high and
  // completes on the rising edge where ack is sampled high; cyc low abandons it.
  logic        core_stb;
  logic        core_cyc;
  logic        core_we;
  logic [3:0]  core_sel;
  logic [23:0] core_adr;
  logic [31:0] core_dat_i;
  logic [2:0]  core_cti;
  logic        core_ack;
  logic [31:0] core_dat_o;

  logic        ram_stb;
  logic        ram_cyc;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [25:0] ram_adr;
  logic [31:0] ram_dat_o;
  logic [2:0]  ram_cti;
  logic        ram_ack;
  logic [31:0] ram_dat_i;

  modport master (
    input  core_stb, core_cyc, core_we, core_sel, core_adr, core_dat_i, core_cti,
    output core_ack, core_dat_o,
    output ram_stb, ram_cyc, ram_we, ram_sel, ram_adr, ram_dat_o, ram_cti,
    input  ram_ack, ram_dat_i
  );

  modport slave (
    output core_stb, core_cyc, core_we, core_sel, core_adr, core_dat_i, core_cti,
    input  core_ack, core_dat_o,
    input  ram_stb, ram_cyc, ram_we, ram_sel, ram_adr, ram_dat_o, ram_cti,
    output ram_ack, ram_dat_i
  );
endinterface

// File: rtl/mem_arbiter_ld_slot.sv
// Single-entry holding slot for ROM-loader writes, with a sticky overrun flag
// for writes that arrive while the slot is still occupied.
module ld_slot (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ld_wr,
  input  logic [24:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic        done,
  output logic        ld_wait,
  output logic        ld_ovr,
  output logic [23:1] slot_addr,
  output logic [15:0] slot_data
);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ld_wait   <= 1'b0;
      ld_ovr    <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
    end else begin
      if (ld_wr && ld_wait) begin
        ld_ovr <= 1'b1;
      end
      if (ld_wr && !ld_wait) begin
        ld_wait   <= 1'b1;
        slot_addr <= ld_addr[23:1];
        slot_data <= ld_data;
      end else if (done) begin
        ld_wait <= 1'b0;
      end
    end
  end

  // The RAM window is 16 MB of halfwords; bit 24 and the byte lane bit are not stored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[24], ld_addr[0]};

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between the CPU core bus and the ROM loader; a pending
// loader write always wins over a new core cycle.
module mem_arbiter
  import archie_mem_pkg::*;
#(
  parameter logic [25:0] LD_BASE = 26'h0400000
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ld_en,
  input  logic          ld_wr,
  input  logic [24:0]   ld_addr,
  input  logic [15:0]   ld_data,
  output logic          ld_wait,
  output logic          ld_ovr,
  mem_arbiter_if.master bus,
  output arb_state_e    state_dbg
);

  arb_state_e  state;
  arb_state_e  state_nxt;
  logic        load_done;
  logic [23:1] slot_addr;
  logic [15:0] slot_data;

  ld_slot u_ld_slot (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .done      (load_done),
    .ld_wait   (ld_wait),
    .ld_ovr    (ld_ovr),
    .slot_addr (slot_addr),
    .slot_data (slot_data)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_done     = 1'b0;
    bus.ram_stb   = 1'b0;
    bus.ram_cyc   = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_sel   = 4'b0000;
    bus.ram_adr   = '0;
    bus.ram_dat_o = '0;
    bus.ram_cti   = CTI_CLASSIC;
    bus.core_ack  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_wait) begin
          state_nxt = ST_LOAD;
        end else if (!ld_en && bus.core_stb && bus.core_cyc) begin
          state_nxt = ST_CORE;
        end
      end
      ST_CORE: begin
        bus.ram_stb   = bus.core_stb;
        bus.ram_cyc   = bus.core_cyc;
        bus.ram_we    = bus.core_we;
        bus.ram_sel   = bus.core_sel;
        bus.ram_adr   = {bus.core_adr, 2'b00};
        bus.ram_dat_o = bus.core_dat_i;
        bus.ram_cti   = bus.core_cti;
        bus.core_ack  = bus.ram_ack;
        if (!bus.core_cyc) begin
          state_nxt = ST_IDLE;
        end else if (bus.ram_ack && cti_ends_cycle(bus.core_cti)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Halfword write: both halves carry the data, the lane select picks one.
        bus.ram_stb   = 1'b1;
        bus.ram_cyc   = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_sel   = slot_addr[1] ? SEL_HI_HALF : SEL_LO_HALF;
        bus.ram_adr   = LD_BASE + {2'b00, slot_addr[23:2], 2'b00};
        bus.ram_dat_o = {slot_data, slot_data};
        bus.ram_cti   = CTI_CLASSIC;
        if (bus.ram_ack) begin
          load_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.core_dat_o = bus.ram_dat_i;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by a randomized mix of
// loader writes and core bursts checked against a transaction-level RAM scoreboard.
module tb_mem_arbiter;
  import archie_mem_pkg::*;

  localparam logic [25:0] LD_BASE = 26'h0400000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ld_en;
  logic        ld_wr;
  logic [24:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_wait;
  logic        ld_ovr;
  arb_state_e  state_dbg;

  logic        man_ack   = 1'b0;
  logic        auto_ack  = 1'b0;
  logic [31:0] ram_rdata = 32'h0;

  mem_arbiter_if bus ();

  assign bus.ram_ack   = man_ack | auto_ack;
  assign bus.ram_dat_i = ram_rdata;

  mem_arbiter #(.LD_BASE(LD_BASE)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ld_en     (ld_en),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_wait   (ld_wait),
    .ld_ovr    (ld_ovr),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / checker ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A RAM beat is {we, sel, byte address, write data}.
  function automatic logic [62:0] exp_ld(input logic [24:0] a, input logic [15:0] d);
    logic [31:0] byte_adr;
    logic [3:0]  s;
    byte_adr = 32'(LD_BASE) + (32'(a) & 32'h00FF_FFFC);
    s = (((a / 2) % 2) == 1) ? 4'b1100 : 4'b0011;
    return {1'b1, s, byte_adr[25:0], {d, d}};
  endfunction

  logic [62:0] exp_q[$];
  bit          sb_en = 1'b0;
  int          ram_wr_cnt = 0;
  logic [62:0] sb_got;
  logic [62:0] sb_want;

  // Every completed RAM beat is counted and, when scoring, matched in order.
  always @(negedge clk_sys) begin
    if (bus.ram_stb && bus.ram_cyc && bus.ram_ack) begin
      if (bus.ram_we) ram_wr_cnt++;
      if (sb_en) begin
        sb_got  = {bus.ram_we, bus.ram_sel, bus.ram_adr, bus.ram_dat_o};
        sb_want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("ram_beat", sb_got, sb_want);
      end
    end
  end

  // ---------------- random-latency RAM responder ----------------
  bit auto_en = 1'b0;
  int lat = 0;

  always begin
    @(posedge clk_sys);
    #2;
    if (auto_ack) begin
      auto_ack = 1'b0;
    end else if (auto_en && bus.ram_stb && bus.ram_cyc) begin
      if (lat == 0) begin
        auto_ack = 1'b1;
        lat = $urandom_range(0, 3);
      end else begin
        lat--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit ovr_exp = 1'b0;

  task automatic next();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ld_idle();
    for (int t = 0; t < 40 && ld_wait; t++) next();
    chk("ld_wait_cleared", ld_wait, 1'b0);
  endtask

  task automatic rand_load();
    logic [24:0] a;
    logic [15:0] d;
    a = 25'($urandom);
    d = 16'($urandom);
    ld_addr = a;
    ld_data = d;
    ld_wr = 1'b1;
    next();
    exp_q.push_back(exp_ld(a, d));
    if ($urandom_range(0, 3) == 0) begin
      ld_addr = 25'($urandom);
      ld_data = 16'($urandom);
      ovr_exp = 1'b1;
      next();
    end
    ld_wr = 1'b0;
    wait_ld_idle();
    #1;
    chk("idle_after_load", state_dbg, ST_IDLE);
  endtask

  task automatic rand_core();
    int          n;
    logic [23:0] a;
    logic        w;
    logic [3:0]  s;
    logic [31:0] d;
    logic        fire;
    logic        got;
    logic [24:0] la;
    logic [15:0] lv;
    n    = $urandom_range(1, 4);
    a    = 24'($urandom);
    w    = 1'($urandom_range(0, 1));
    fire = (n > 1) && ($urandom_range(0, 1) == 1);
    la   = 25'($urandom);
    lv   = 16'($urandom);
    bus.core_cyc = 1'b1;
    for (int b = 0; b < n; b++) begin
      s = 4'($urandom);
      d = $urandom;
      bus.core_stb   = 1'b1;
      bus.core_we    = w;
      bus.core_sel   = s;
      bus.core_adr   = a + 24'(b);
      bus.core_dat_i = d;
      bus.core_cti   = (n == 1) ? CTI_CLASSIC : ((b == n - 1) ? CTI_EOB : CTI_INCR);
      ram_rdata      = $urandom;
      if (fire && b == 1) begin
        ld_addr = la;
        ld_data = lv;
        ld_wr   = 1'b1;
      end
      exp_q.push_back({w, s, 26'(32'(a + 24'(b)) * 4), d});
      got = 1'b0;
      for (int t = 0; t < 30 && !got; t++) begin
        @(negedge clk_sys);
        if (bus.core_ack) begin
          got = 1'b1;
          chk("core_dat_o", bus.core_dat_o, ram_rdata);
        end
        next();
        ld_wr = 1'b0;
      end
      chk("core_beat_acked", got, 1'b1);
    end
    bus.core_stb = 1'b0;
    bus.core_cyc = 1'b0;
    if (fire) exp_q.push_back(exp_ld(la, lv));
    wait_ld_idle();
    #1;
    chk("idle_after_core", state_dbg, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  int w0;

  initial begin
    reset_n = 1'b0;
    ld_en   = 1'b0;
    ld_wr   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    bus.core_stb   = 1'b0;
    bus.core_cyc   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_sel   = 4'h0;
    bus.core_adr   = '0;
    bus.core_dat_i = '0;
    bus.core_cti   = CTI_CLASSIC;

    // reset state
    repeat (3) next();
    #1;
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_ld_wait", ld_wait, 1'b0);
    chk("rst_ld_ovr", ld_ovr, 1'b0);
    chk("rst_ram_stb", bus.ram_stb, 1'b0);
    chk("rst_core_ack", bus.core_ack, 1'b0);
    reset_n = 1'b1;

    // single loader write from idle
    next();
    ld_addr = 25'h000006;
    ld_data = 16'hBEEF;
    ld_wr   = 1'b1;
    next();
    ld_wr = 1'b0;
    #1;
    chk("ld1_wait_set", ld_wait, 1'b1);
    chk("ld1_still_idle", state_dbg, ST_IDLE);
    next();
    #1;
    chk("ld1_state", state_dbg, ST_LOAD);
    chk("ld1_ram_stb", bus.ram_stb, 1'b1);
    chk("ld1_ram_we", bus.ram_we, 1'b1);
    chk("ld1_ram_adr", bus.ram_adr, 26'h0400004);
    chk("ld1_ram_sel", bus.ram_sel, 4'b1100);
    chk("ld1_ram_dat", bus.ram_dat_o, 32'hBEEFBEEF);
    chk("ld1_ram_cti", bus.ram_cti, 3'b000);
    man_ack = 1'b1;
    #1;
    chk("ld1_no_core_ack", bus.core_ack, 1'b0);
    next();
    man_ack = 1'b0;
    #1;
    chk("ld1_wait_clear", ld_wait, 1'b0);
    chk("ld1_back_idle", state_dbg, ST_IDLE);
    chk("ld1_stb_off", bus.ram_stb, 1'b0);

    // 4-beat core read burst
    bus.core_cyc = 1'b1;
    bus.core_stb = 1'b1;
    bus.core_we  = 1'b0;
    bus.core_sel = 4'hF;
    bus.core_adr = 24'h000100;
    bus.core_cti = CTI_INCR;
    next();
    for (int b = 0; b < 4; b++) begin
      bus.core_adr = 24'h000100 + 24'(b);
      bus.core_cti = (b == 3) ? CTI_EOB : CTI_INCR;
      ram_rdata = $urandom;
      man_ack = 1'b1;
      #1;
      chk("burst_state", state_dbg, ST_CORE);
      chk("burst_ram_adr", bus.ram_adr, 26'((32'h100 + b) * 4));
      chk("burst_core_ack", bus.core_ack, 1'b1);
      chk("burst_dat_o", bus.core_dat_o, ram_rdata);
      next();
    end
    man_ack = 1'b0;
    bus.core_stb = 1'b0;
    bus.core_cyc = 1'b0;
    #1;
    chk("burst_end_idle", state_dbg, ST_IDLE);
    chk("burst_end_no_ack", bus.core_ack, 1'b0);

    // loader write during beat 2 of a burst, new core request waiting behind it
    bus.core_cyc = 1'b1;
    bus.core_stb = 1'b1;
    bus.core_adr = 24'h000200;
    bus.core_cti = CTI_INCR;
    next();
    for (int b = 0; b < 4; b++) begin
      bus.core_adr = 24'h000200 + 24'(b);
      bus.core_cti = (b == 3) ? CTI_EOB : CTI_INCR;
      man_ack = 1'b1;
      if (b == 1) begin
        ld_addr = 25'h123456;
        ld_data = 16'h5A5A;
        ld_wr   = 1'b1;
      end
      #1;
      chk("mix_state_core", state_dbg, ST_CORE);
      chk("mix_core_ack", bus.core_ack, 1'b1);
      next();
      ld_wr = 1'b0;
    end
    bus.core_adr = 24'h000300;
    bus.core_cti = CTI_CLASSIC;
    man_ack = 1'b0;
    #1;
    chk("mix_after_eob_idle", state_dbg, ST_IDLE);
    chk("mix_wait_held", ld_wait, 1'b1);
    next();
    #1;
    chk("mix_load_first", state_dbg, ST_LOAD);
    chk("mix_ram_adr", bus.ram_adr, 26'h0523454);
    chk("mix_ram_sel", bus.ram_sel, 4'b1100);
    chk("mix_ram_dat", bus.ram_dat_o, 32'h5A5A5A5A);
    man_ack = 1'b1;
    #1;
    chk("mix_load_no_core_ack", bus.core_ack, 1'b0);
    next();
    man_ack = 1'b0;
    #1;
    chk("mix_load_done", ld_wait, 1'b0);
    next();
    #1;
    chk("mix_core_regrant", state_dbg, ST_CORE);
    chk("mix_core_adr", bus.ram_adr, 26'h0000C00);
    man_ack = 1'b1;
    next();
    man_ack = 1'b0;
    bus.core_stb = 1'b0;
    bus.core_cyc = 1'b0;
    #1;
    chk("mix_final_idle", state_dbg, ST_IDLE);

    // overrun: second write one cycle later, ack delayed
    w0 = ram_wr_cnt;
    ld_addr = 25'h000010;
    ld_data = 16'h1111;
    ld_wr   = 1'b1;
    next();
    ld_addr = 25'h000022;
    ld_data = 16'h2222;
    next();
    ld_wr = 1'b0;
    #1;
    chk("ovr_flag", ld_ovr, 1'b1);
    chk("ovr_state", state_dbg, ST_LOAD);
    chk("ovr_ram_adr", bus.ram_adr, 26'h0400010);
    chk("ovr_ram_dat", bus.ram_dat_o, 32'h11111111);
    chk("ovr_ram_sel", bus.ram_sel, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      next();
      #1;
      chk("ovr_hold_load", state_dbg, ST_LOAD);
      chk("ovr_hold_adr", bus.ram_adr, 26'h0400010);
    end
    man_ack = 1'b1;
    next();
    man_ack = 1'b0;
    #1;
    chk("ovr_idle", state_dbg, ST_IDLE);
    chk("ovr_wait_clear", ld_wait, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next();
      #1;
      chk("ovr_no_second_write", bus.ram_stb, 1'b0);
    end
    chk("ovr_write_count", 64'(ram_wr_cnt - w0), 64'd1);
    chk("ovr_sticky", ld_ovr, 1'b1);

    // ld_en blocks core grants
    ld_en = 1'b1;
    bus.core_cyc = 1'b1;
    bus.core_stb = 1'b1;
    bus.core_cti = CTI_CLASSIC;
    for (int i = 0; i < 20; i++) begin
      man_ack = 1'($urandom_range(0, 1));
      next();
      #1;
      chk("lden_core_ack", bus.core_ack, 1'b0);
      chk("lden_ram_stb", bus.ram_stb, 1'b0);
    end
    man_ack = 1'b0;
    bus.core_cyc = 1'b0;
    bus.core_stb = 1'b0;
    ld_en = 1'b0;

    // reset in the middle of a loader write
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    #1;
    chk("rst_clears_ovr", ld_ovr, 1'b0);
    ld_addr = 25'h000040;
    ld_data = 16'h3333;
    ld_wr   = 1'b1;
    next();
    ld_wr = 1'b0;
    next();
    #1;
    chk("rstld_in_load", state_dbg, ST_LOAD);
    reset_n = 1'b0;
    next();
    #1;
    chk("rstld_idle", state_dbg, ST_IDLE);
    chk("rstld_wait", ld_wait, 1'b0);
    chk("rstld_stb", bus.ram_stb, 1'b0);
    reset_n = 1'b1;
    man_ack = 1'b1;
    #1;
    chk("rstld_late_ack", bus.core_ack, 1'b0);
    next();
    man_ack = 1'b0;
    #1;
    chk("rstld_stay_idle", state_dbg, ST_IDLE);
    next();
    #1;
    chk("rstld_no_reload", bus.ram_stb, 1'b0);

    // randomized mix against the scoreboard
    ovr_exp = 1'b0;
    sb_en   = 1'b1;
    auto_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) rand_load();
      else rand_core();
    end
    repeat (3) next();
    auto_en = 1'b0;
    sb_en   = 1'b0;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_ovr", ld_ovr, ovr_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LD_BASE, default 26'h0400000, byte offset added to every loader address.
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 ld_en  in  1  ROM download active; ld_wr  in  1  loader write strobe; ld_addr  in  25  byte address; ld_data  in  16  halfword.
REQ-005 ld_wait  out  1  loader write pending; ld_ovr  out  1  sticky overrun flag.
REQ-006 core_stb, core_cyc, core_we  in  1 each; core_sel  in  4; core_adr  in  24  word address [25:2]; core_dat_i  in  32; core_cti  in  3.
REQ-007 core_ack  out  1; core_dat_o  out  32  read data.
REQ-008 ram_stb, ram_cyc, ram_we  out  1 each; ram_sel  out  4; ram_adr  out  26  byte address, bits [1:0]=0; ram_dat_o  out  32; ram_cti  out  3.
REQ-009 ram_ack  in  1; ram_dat_i  in  32.

Function
REQ-010 The FSM SHALL have states IDLE, CORE and LOAD, encoded as a 2-bit register.
REQ-011 ld_wr high at edge E SHALL latch ld_addr/ld_data into a pending slot and set ld_wait from E; ld_wait SHALL clear on the edge where ram_ack is sampled in LOAD.
REQ-012 ld_wr while ld_wait is high SHALL be ignored (slot unchanged) and SHALL set ld_ovr; ld_ovr clears only on reset.
REQ-013 In IDLE, a pending loader slot SHALL move to LOAD at the next edge; loader has priority over core.
REQ-014 In IDLE with no pending slot, ld_en low and core_stb&core_cyc high, the FSM SHALL move to CORE at the next edge.
REQ-015 While ld_en is high, core requests SHALL NOT be granted and core_ack SHALL stay 0.
REQ-016 In LOAD: ram_stb=ram_cyc=ram_we=1; ram_sel=4'b1100 if slot addr[1] else 4'b0011; ram_adr=LD_BASE+{addr[23:2],2'b00} truncated to 26 bits; ram_dat_o={data,data}; ram_cti=3'b000.
REQ-017 In CORE, ram_stb/cyc/we/sel/dat_o/cti SHALL pass core signals combinationally; ram_adr={core_adr,2'b00}; core_ack=ram_ack.
REQ-018 In CORE, ram_ack with core_cti equal to 3'b000 or 3'b111 SHALL return to IDLE at that edge; burst cycles (3'b010) keep the grant.
REQ-019 In CORE, core_cyc sampled low SHALL return to IDLE at that edge (abandoned cycle).
REQ-020 In IDLE, all ram_* strobes and core_ack SHALL be 0.
REQ-021 core_dat_o SHALL equal ram_dat_i at all times; validity is qualified by core_ack.
REQ-022 After LOAD completes, FSM SHALL return to IDLE; back-to-back loader writes SHALL take at least 2 cycles each.
REQ-023 ld_wr arriving during CORE SHALL be held pending until the core cycle ends, then granted before any new core request.

Reset
REQ-024 reset_n low at an edge SHALL force IDLE, clear pending slot, ld_wait=0, ld_ovr=0, all ram strobes=0, core_ack=0, regardless of an outstanding ram cycle.
REQ-025 A ram_ack arriving after reset SHALL be ignored.

Structure
REQ-026 The state enumeration and the CTI constants (CLASSIC=000, INCR=010, EOB=111) SHALL live in a shared package archie_mem_pkg.
REQ-027 The loader pending slot (latch, wait, overrun) SHALL be one sub-module, ld_slot; the FSM and mux SHALL stay in mem_arbiter.

Verification
REQ-028 Loader write ld_addr=0x000006, ld_data=0xBEEF, idle -> next cycle ram_adr=0x0400004, ram_sel=1100, ram_dat_o=0xBEEFBEEF; ld_wait clears on ram_ack.
REQ-029 Core 4-beat read burst (cti 010,010,010,111), ld_en=0 -> 4 core_ack pulses; IDLE after the 4th ack.
REQ-030 ld_wr during beat 2 of a core burst -> LOAD entered only after the EOB ack; the write lands at LD_BASE+addr.
REQ-031 Two ld_wr 1 cycle apart with ram_ack delayed 5 cycles -> second ignored, ld_ovr=1, one ram write only.
REQ-032 ld_en=1 with core_stb=1 held 20 cycles -> core_ack stays 0, ram_stb=0 absent loader traffic.
REQ-033 reset_n low during LOAD before ack -> next cycle IDLE, ld_wait=0, ram_stb=0; a late ram_ack produces no core_ack.
